// File: rtl/roic_crc_pkg.sv
// roic_crc_pkg
//   Shared definitions for the ROIC CRC-12 line framer and, later, the
//   receive-side checker.
//   - CRC_W      : width of pixel words and of the CRC word.
//   - CRC_POLY   : low 12 bits of x^12+x^10+x^7+x^4+x^3+x^2+x+1.
//   - framer_st_t: framer FSM state encoding.
//   - crc12_d12  : one 12-bit parallel CRC update, D[11] shifted in first.
package roic_crc_pkg;

    localparam int CRC_W = 12;
    localparam logic [CRC_W-1:0] CRC_POLY = 12'h49F;

    typedef enum logic {ST_DATA, ST_CRC} framer_st_t;

    // Unrolled bit-serial LFSR: twelve feedback steps, MSB of the data word
    // first. Synthesis flattens this into one XOR network per output bit.
    function automatic logic [CRC_W-1:0] crc12_d12(
        input logic [CRC_W-1:0] data,
        input logic [CRC_W-1:0] crc
    );
        logic [CRC_W-1:0] c;
        logic             fb;
        c = crc;
        for (int i = CRC_W - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ data[i];
            c  = {c[CRC_W-2:0], 1'b0};
            if (fb) begin
                c = c ^ CRC_POLY;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc12_d12_comb.sv
// crc12_d12_comb
//   Purely combinational CRC-12 next-state block, a thin wrapper around
//   roic_crc_pkg::crc12_d12 so transmit and receive sides share one netlist
//   description.
//   Ports:
//     data_i : 12-bit data word folded into the CRC
//     crc_i  : current CRC register value
//     crc_o  : CRC after absorbing data_i
module crc12_d12_comb
    import roic_crc_pkg::*;
(
    input  logic [CRC_W-1:0] data_i,
    input  logic [CRC_W-1:0] crc_i,
    output logic [CRC_W-1:0] crc_o
);

    assign crc_o = crc12_d12(data_i, crc_i);

endmodule

// File: rtl/roic_crc12_line_framer.sv
// roic_crc12_line_framer
//   Forwards LINE_LEN 12-bit pixel words per line unchanged and appends one
//   CRC-12 word after the last word of each line.
//   Parameters:
//     LINE_LEN : data words per line (1..4095)
//     CRC_INIT : CRC seed at reset, on clr and after each CRC word
//   Ports:
//     clk, rst_n         : clock, asynchronous active-low reset
//     clr                : synchronous abort of the current line
//     s_data/s_valid/s_ready          : pixel input stream
//     m_data/m_valid/m_ready          : output stream (pixels then CRC)
//     m_last, m_is_crc   : output word is the CRC word closing its line
//     line_cnt           : completed lines, wraps at 16 bits
//     busy               : a line is partially accepted or CRC is pending
//
// Handshake: a word moves on a rising edge when valid && ready are both high
// there. valid never waits on ready; once m_valid is high, m_data, m_last and
// m_is_crc hold until the edge where m_ready is sampled high. s_ready is
// combinational from the FSM state, m_valid and m_ready.
module roic_crc12_line_framer
    import roic_crc_pkg::*;
#(
    parameter int unsigned      LINE_LEN = 64,
    parameter logic [CRC_W-1:0] CRC_INIT = 12'h000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [CRC_W-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [CRC_W-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             m_is_crc,
    output logic [15:0]      line_cnt,
    output logic             busy
);

    localparam int unsigned      CNT_W    = $clog2(LINE_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    framer_st_t       state_q, state_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [CRC_W-1:0] m_data_q, m_data_d;
    logic             m_valid_q, m_valid_d;
    logic             m_last_q, m_last_d;
    logic             m_is_crc_q, m_is_crc_d;
    logic [15:0]      line_cnt_q, line_cnt_d;

    logic             load;
    logic             accept;
    logic             last_word;
    logic [CRC_W-1:0] crc_next;

    // The output slice may take a new word when empty or being drained.
    assign load      = !m_valid_q || m_ready;
    assign accept    = s_valid && s_ready;
    assign last_word = (word_cnt_q == LAST_IDX);

    crc12_d12_comb u_crc (
        .data_i (s_data),
        .crc_i  (crc_q),
        .crc_o  (crc_next)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_DATA;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ST_DATA;
        end else begin
            case (state_q)
                ST_DATA: if (accept && last_word) state_d = ST_CRC;
                ST_CRC:  if (load)                state_d = ST_DATA;
                default:                          state_d = ST_DATA;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    // Input is closed while the CRC word waits for the output slice, which
    // costs exactly one input cycle per line at full rate.
    always_comb begin
        s_ready = 1'b0;
        case (state_q)
            ST_DATA: s_ready = load;
            ST_CRC:  s_ready = 1'b0;
            default: s_ready = 1'b0;
        endcase
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        word_cnt_d = word_cnt_q;
        crc_d      = crc_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        m_last_d   = m_last_q;
        m_is_crc_d = m_is_crc_q;
        line_cnt_d = line_cnt_q;

        if (clr) begin
            // Abort: any word presented this cycle is dropped, line_cnt kept.
            word_cnt_d = '0;
            crc_d      = CRC_INIT;
            m_valid_d  = 1'b0;
            m_last_d   = 1'b0;
            m_is_crc_d = 1'b0;
        end else if (state_q == ST_DATA) begin
            if (accept) begin
                m_data_d   = s_data;
                m_valid_d  = 1'b1;
                m_last_d   = 1'b0;
                m_is_crc_d = 1'b0;
                crc_d      = crc_next;
                word_cnt_d = last_word ? '0 : word_cnt_q + CNT_ONE;
            end else if (load) begin
                m_valid_d  = 1'b0;
            end
        end else begin
            if (load) begin
                // CRC word is emitted but never folded back into the CRC.
                m_data_d   = crc_q;
                m_valid_d  = 1'b1;
                m_last_d   = 1'b1;
                m_is_crc_d = 1'b1;
                crc_d      = CRC_INIT;
                line_cnt_d = line_cnt_q + 16'd1;
            end
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_q <= '0;
            crc_q      <= CRC_INIT;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            m_is_crc_q <= 1'b0;
            line_cnt_q <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
            crc_q      <= crc_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            m_is_crc_q <= m_is_crc_d;
            line_cnt_q <= line_cnt_d;
        end
    end

    assign m_data   = m_data_q;
    assign m_valid  = m_valid_q;
    assign m_last   = m_last_q;
    assign m_is_crc = m_is_crc_q;
    assign line_cnt = line_cnt_q;
    assign busy     = (word_cnt_q != '0) || (state_q == ST_CRC);

endmodule

// File: tb/tb_roic_crc12_line_framer.sv
// tb_roic_crc12_line_framer
//   Directed and randomised checks of the CRC-12 line framer: one instance
//   with LINE_LEN=4 and one with LINE_LEN=1.
module tb_roic_crc12_line_framer;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT with LINE_LEN = 4 ----------------
    logic        clr;
    logic [11:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [11:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic        m_is_crc;
    logic [15:0] line_cnt;
    logic        busy;

    roic_crc12_line_framer #(.LINE_LEN(4), .CRC_INIT(12'h000)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_last   (m_last),
        .m_is_crc (m_is_crc),
        .line_cnt (line_cnt),
        .busy     (busy)
    );

    // ---------------- DUT with LINE_LEN = 1 ----------------
    logic        clr1;
    logic [11:0] s1_data;
    logic        s1_valid;
    logic        s1_ready;
    logic [11:0] m1_data;
    logic        m1_valid;
    logic        m1_ready;
    logic        m1_last;
    logic        m1_is_crc;
    logic [15:0] line_cnt1;
    logic        busy1;

    roic_crc12_line_framer #(.LINE_LEN(1), .CRC_INIT(12'h000)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr1),
        .s_data   (s1_data),
        .s_valid  (s1_valid),
        .s_ready  (s1_ready),
        .m_data   (m1_data),
        .m_valid  (m1_valid),
        .m_ready  (m1_ready),
        .m_last   (m1_last),
        .m_is_crc (m1_is_crc),
        .line_cnt (line_cnt1),
        .busy     (busy1)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Link-side reference: with a 12-bit word into a 12-bit CRC the update is
    // ((crc ^ data) * x^12) mod P, done here as long division.
    function automatic logic [11:0] next_crc12_d12(input logic [11:0] d, input logic [11:0] c);
        logic [23:0] r;
        r = {d ^ c, 12'h000};
        for (int i = 23; i >= 12; i--) begin
            if (r[i]) r[i -: 13] = r[i -: 13] ^ 13'h149F;
        end
        return r[11:0];
    endfunction

    // ---------------- scoreboard (LINE_LEN = 4 instance) ----------------
    logic [12:0] exp_q[$];          // {is_crc, data}
    logic        mon_en       = 1'b0;
    logic [11:0] mdl_crc      = 12'h000;
    int          mdl_cnt      = 0;
    logic        stall_prev   = 1'b0;
    logic [13:0] stall_word   = '0;
    logic [11:0] last_crc_out = 12'hFFF;

    always @(negedge clk) begin
        logic [12:0] e;
        if (!mon_en) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", {31'd0, m_valid}, 32'd1);
                check("stall_word", {18'd0, m_last, m_is_crc, m_data}, {18'd0, stall_word});
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", {20'd0, m_data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("out_word", {19'd0, m_is_crc, m_data}, {19'd0, e});
                    check("out_last", {31'd0, m_last}, {31'd0, e[12]});
                    if (e[12]) last_crc_out = m_data;
                end
            end
            stall_prev = m_valid && !m_ready;
            stall_word = {m_last, m_is_crc, m_data};
            if (clr) begin
                exp_q.delete();
                mdl_crc    = 12'h000;
                mdl_cnt    = 0;
                stall_prev = 1'b0;
            end else if (s_valid && s_ready) begin
                exp_q.push_back({1'b0, s_data});
                mdl_crc = next_crc12_d12(s_data, mdl_crc);
                mdl_cnt++;
                if (mdl_cnt == 4) begin
                    exp_q.push_back({1'b1, mdl_crc});
                    mdl_crc = 12'h000;
                    mdl_cnt = 0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word and hold it until accepted; returns 1 ns after the
    // accepting edge.
    task automatic send_word(input logic [11:0] d);
        int n;
        n       = 0;
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic send_line(input logic [11:0] a, input logic [11:0] b,
                             input logic [11:0] c, input logic [11:0] d);
        send_word(a);
        send_word(b);
        send_word(c);
        send_word(d);
    endtask

    task automatic reset_model();
        exp_q.delete();
        mdl_crc = 12'h000;
        mdl_cnt = 0;
    endtask

    logic rnd_done = 1'b0;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n    = 1'b1;
        clr      = 1'b0;
        s_data   = '0;
        s_valid  = 1'b0;
        m_ready  = 1'b1;
        clr1     = 1'b0;
        s1_data  = '0;
        s1_valid = 1'b0;
        m1_ready = 1'b1;

        // Reset state.
        #2 rst_n = 1'b0;
        #1;
        check("rst_s_ready", {31'd0, s_ready}, 32'd1);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_data", {20'd0, m_data}, 32'd0);
        check("rst_m_last", {31'd0, m_last}, 32'd0);
        check("rst_m_is_crc", {31'd0, m_is_crc}, 32'd0);
        check("rst_line_cnt", {16'd0, line_cnt}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick();

        // Line 0,0,0,1 at full rate: CRC 0x49F one cycle after the last word.
        last_crc_out = 12'hFFF;
        send_line(12'h000, 12'h000, 12'h000, 12'h001);
        check("t1_last_data", {20'd0, m_data}, 32'h001);
        check("t1_s_ready_low", {31'd0, s_ready}, 32'd0);
        check("t1_busy_crc", {31'd0, busy}, 32'd1);
        tick();
        check("t1_crc_word", {20'd0, m_data}, 32'h49F);
        check("t1_crc_last", {31'd0, m_last}, 32'd1);
        check("t1_crc_flag", {31'd0, m_is_crc}, 32'd1);
        check("t1_line_cnt", {16'd0, line_cnt}, 32'd1);
        check("t1_s_ready_back", {31'd0, s_ready}, 32'd1);
        repeat (2) tick();
        check("t1_seen_crc", {20'd0, last_crc_out}, 32'h49F);

        // All-zero line, then the first line again: seed reloads per line.
        last_crc_out = 12'hFFF;
        send_line(12'h000, 12'h000, 12'h000, 12'h000);
        repeat (3) tick();
        check("t2_zero_crc", {20'd0, last_crc_out}, 32'h000);
        last_crc_out = 12'hFFF;
        send_line(12'h000, 12'h000, 12'h000, 12'h001);
        repeat (3) tick();
        check("t2_reseed_crc", {20'd0, last_crc_out}, 32'h49F);
        check("t2_line_cnt", {16'd0, line_cnt}, 32'd3);

        // clr after two words, with a third word presented in the same cycle.
        send_word(12'h123);
        send_word(12'h456);
        s_valid = 1'b1;
        s_data  = 12'h789;
        clr     = 1'b1;
        tick();
        clr     = 1'b0;
        s_valid = 1'b0;
        check("clr_m_valid", {31'd0, m_valid}, 32'd0);
        check("clr_busy", {31'd0, busy}, 32'd0);
        check("clr_line_cnt", {16'd0, line_cnt}, 32'd3);
        last_crc_out = 12'hFFF;
        send_line(12'h000, 12'h000, 12'h000, 12'h001);
        repeat (3) tick();
        check("clr_next_crc", {20'd0, last_crc_out}, 32'h49F);
        check("clr_next_line_cnt", {16'd0, line_cnt}, 32'd4);

        // 1000 random lines with input gaps and output backpressure.
        fork
            begin
                for (int ln = 0; ln < 1000; ln++) begin
                    for (int w = 0; w < 4; w++) begin
                        repeat ($urandom_range(0, 2)) tick();
                        send_word(12'($urandom_range(0, 4095)));
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    tick();
                    m_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        m_ready = 1'b1;
        repeat (5) tick();
        check("rnd_drained", exp_q.size(), 32'd0);
        check("rnd_line_cnt", {16'd0, line_cnt}, 32'd1004);

        // Reset while the CRC word is pending under backpressure.
        send_line(12'h111, 12'h222, 12'h333, 12'h444);
        m_ready = 1'b0;
        mon_en  = 1'b0;
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        check("pre_rst_hold", {20'd0, m_data}, 32'h444);
        #2 rst_n = 1'b0;
        #1;
        check("arst_s_ready", {31'd0, s_ready}, 32'd1);
        check("arst_m_valid", {31'd0, m_valid}, 32'd0);
        check("arst_m_data", {20'd0, m_data}, 32'd0);
        check("arst_m_last", {31'd0, m_last}, 32'd0);
        check("arst_m_is_crc", {31'd0, m_is_crc}, 32'd0);
        check("arst_line_cnt", {16'd0, line_cnt}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        m_ready = 1'b1;
        mon_en  = 1'b1;
        tick();
        last_crc_out = 12'hFFF;
        send_line(12'h000, 12'h000, 12'h000, 12'h001);
        repeat (3) tick();
        check("arst_clean_crc", {20'd0, last_crc_out}, 32'h49F);
        check("arst_line_cnt_1", {16'd0, line_cnt}, 32'd1);

        // LINE_LEN = 1 at full rate: output alternates data / CRC.
        s1_data  = 12'h001;
        s1_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k % 2 == 0) begin
                check("l1_data", {20'd0, m1_data}, 32'h001);
                check("l1_flag_d", {31'd0, m1_is_crc}, 32'd0);
                check("l1_s_ready_lo", {31'd0, s1_ready}, 32'd0);
            end else begin
                check("l1_crc", {20'd0, m1_data}, 32'h49F);
                check("l1_flag_c", {30'd0, m1_last, m1_is_crc}, 32'd3);
                check("l1_s_ready_hi", {31'd0, s1_ready}, 32'd1);
            end
        end
        s1_valid = 1'b0;
        check("l1_line_cnt", {16'd0, line_cnt1}, 32'd4);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
